// File: rtl/nxm_matrix_pkg.sv
// Shared encodings for the NxM bolometer matrix sequencer and its datapath.
package nxm_matrix_pkg;

  // Counter op-codes; 2'b11 is treated as hold.
  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_HOLD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;

  localparam int DEF_N_ROWS = 2;
  localparam int DEF_N_COLS = 2;

endpackage

// File: rtl/nxm_matrix_datapath_if.sv
// Handshake bundle between the matrix sequencing FSM (master) and the datapath (slave).
interface nxm_matrix_datapath_if #(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int CNT_W  = 2,
  parameter int ADC_W  = 12
);
  logic [1:0]        oprow_i;
  logic [1:0]        opcol_i;
  logic              enset_i;
  logic              enleds_i;
  logic              eoadc_i;
  logic [ADC_W-1:0]  adc_data_i;
  logic [CNT_W-1:0]  count_row_o;
  logic [CNT_W-1:0]  count_col_o;
  logic              zset_o;
  logic              zleds_o;
  logic [N_ROWS-1:0] row_sel_o;
  logic [N_COLS-1:0] col_sel_o;
  logic [ADC_W-1:0]  pixel_data_o;
  logic [CNT_W-1:0]  pixel_row_o;
  logic [CNT_W-1:0]  pixel_col_o;
  logic              pixel_valid_o;
  logic [7:0]        leds_o;
  logic              frame_done_o;

  modport master (
    output oprow_i, opcol_i, enset_i, enleds_i, eoadc_i, adc_data_i,
    input  count_row_o, count_col_o, zset_o, zleds_o, row_sel_o, col_sel_o,
    input  pixel_data_o, pixel_row_o, pixel_col_o, pixel_valid_o, leds_o, frame_done_o
  );

  modport slave (
    input  oprow_i, opcol_i, enset_i, enleds_i, eoadc_i, adc_data_i,
    output count_row_o, count_col_o, zset_o, zleds_o, row_sel_o, col_sel_o,
    output pixel_data_o, pixel_row_o, pixel_col_o, pixel_valid_o, leds_o, frame_done_o
  );
endinterface

// File: rtl/nxm_dwell_timer.sv
// Dwell timer: done asserts in the CYCLES-th consecutive enabled cycle and holds while enabled.
module nxm_dwell_timer #(
  parameter int CYCLES = 4,
  parameter int TMR_W  = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic done_o
);
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(CYCLES - 1);

  logic [TMR_W-1:0] r_val;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_val <= '0;
    end else if (!en_i) begin
      r_val <= RELOAD;
    end else if (r_val != '0) begin
      r_val <= r_val - TMR_W'(1);
    end
  end

  assign done_o = en_i && (r_val == '0);

endmodule

// File: rtl/nxm_matrix_datapath.sv
// Datapath slave for the NxM matrix FSM: row/col counters, dwell timers, switch selects, ADC capture.
module nxm_matrix_datapath
  import nxm_matrix_pkg::*;
#(
  parameter int N_ROWS        = DEF_N_ROWS,
  parameter int N_COLS        = DEF_N_COLS,
  parameter int CNT_W         = 2,
  parameter int ADC_W         = 12,
  parameter int SETTLE_CYCLES = 50000,
  parameter int LED_CYCLES    = 25000000,
  parameter int TMR_W         = 25
) (
  input logic clk_i,
  input logic rst_i,
  nxm_matrix_datapath_if.slave bus
);

  logic [CNT_W-1:0]  r_count_row;
  logic [CNT_W-1:0]  r_count_col;
  logic [CNT_W-1:0]  w_row_inc;
  logic              r_primed;
  logic              r_pixel_valid;
  logic              r_frame_done;
  logic [ADC_W-1:0]  r_pixel_data;
  logic [CNT_W-1:0]  r_pixel_row;
  logic [CNT_W-1:0]  r_pixel_col;
  logic [7:0]        r_leds;
  logic              w_row_clr;
  logic              w_capture;
  logic              w_zset;
  logic              w_zleds;
  logic [N_ROWS-1:0] w_row_sel;
  logic [N_COLS-1:0] w_col_sel;

  function automatic logic [CNT_W-1:0] next_count(input logic [1:0] op,
                                                  input logic [CNT_W-1:0] cnt);
    case (op)
      OP_CLR:  return '0;
      OP_INC:  return cnt + CNT_W'(1);
      default: return cnt;
    endcase
  endfunction

  assign w_row_inc = r_count_row + CNT_W'(1);
  assign w_row_clr = (bus.oprow_i == OP_CLR);
  // A conversion coinciding with a row clear belongs to the next frame's dummy slot.
  assign w_capture = bus.eoadc_i && r_primed && !w_row_clr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count_row <= '0;
      r_count_col <= '0;
    end else begin
      r_count_row <= next_count(bus.oprow_i, r_count_row);
      r_count_col <= next_count(bus.opcol_i, r_count_col);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_primed      <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_pixel_data  <= '0;
      r_pixel_row   <= '0;
      r_pixel_col   <= '0;
      r_leds        <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_row_clr)         r_primed <= 1'b0;
      else if (bus.eoadc_i)  r_primed <= 1'b1;
      r_pixel_valid <= w_capture;
      if (w_capture) begin
        r_pixel_data <= bus.adc_data_i;
        r_pixel_row  <= r_count_row;
        r_pixel_col  <= r_count_col;
      end
      r_leds       <= bus.enleds_i ? r_pixel_data[ADC_W-1 -: 8] : 8'h00;
      r_frame_done <= (bus.oprow_i == OP_INC) && (w_row_inc == CNT_W'(N_ROWS));
    end
  end

  always_comb begin
    w_row_sel = '0;
    w_col_sel = '0;
    for (int i = 0; i < N_ROWS; i++) w_row_sel[i] = (r_count_row == CNT_W'(i));
    for (int j = 0; j < N_COLS; j++) w_col_sel[j] = (r_count_col == CNT_W'(j));
  end

  nxm_dwell_timer #(.CYCLES(SETTLE_CYCLES), .TMR_W(TMR_W)) u_settle_tmr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (bus.enset_i),
    .done_o (w_zset)
  );

  nxm_dwell_timer #(.CYCLES(LED_CYCLES), .TMR_W(TMR_W)) u_leds_tmr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (bus.enleds_i),
    .done_o (w_zleds)
  );

  assign bus.count_row_o   = r_count_row;
  assign bus.count_col_o   = r_count_col;
  assign bus.zset_o        = w_zset;
  assign bus.zleds_o       = w_zleds;
  assign bus.row_sel_o     = w_row_sel;
  assign bus.col_sel_o     = w_col_sel;
  assign bus.pixel_data_o  = r_pixel_data;
  assign bus.pixel_row_o   = r_pixel_row;
  assign bus.pixel_col_o   = r_pixel_col;
  assign bus.pixel_valid_o = r_pixel_valid;
  assign bus.leds_o        = r_leds;
  assign bus.frame_done_o  = r_frame_done;

endmodule

// File: doc/nxm_matrix_datapath.md
Name: nxm_matrix_datapath

Overview:
- Datapath slave to the NxM bolometer matrix sequencing FSM.
- Executes the FSM's row/column counter op-codes and returns counts for its end-of-row/end-of-matrix decisions.
- Generates the settle-time (zset) and LED-display-time (zleds) done flags, and drives one-hot row/column analog-switch selects.
- Captures ADC results tagged with pixel coordinates, discarding the dummy conversion issued at the start of each frame.

Parameters:
- N_ROWS, 2, rows in matrix (1..3)
- N_COLS, 2, columns in matrix (1..3)
- CNT_W, 2, width of row/column counters
- ADC_W, 12, ADC result width
- SETTLE_CYCLES, 50000, clocks enset_i must stay high before zset_o (>=1)
- LED_CYCLES, 25000000, clocks enleds_i must stay high before zleds_o (>=1)
- TMR_W, 25, timer width (must hold max(SETTLE_CYCLES, LED_CYCLES))

Ports:
- clk_i, input, 1, system clock
- rst_i, input, 1, asynchronous active-high reset
- oprow_i, input, 2, row counter op: 00 clear, 01 hold, 10 increment, 11 hold
- opcol_i, input, 2, column counter op, same encoding
- enset_i, input, 1, settle timer enable
- enleds_i, input, 1, LED display timer enable
- eoadc_i, input, 1, end-of-conversion pulse from ADC controller
- adc_data_i, input, ADC_W, conversion result, valid while eoadc_i=1
- count_row_o, output, CNT_W, current row count
- count_col_o, output, CNT_W, current column count
- zset_o, output, 1, settle time elapsed
- zleds_o, output, 1, LED display time elapsed
- row_sel_o, output, N_ROWS, one-hot row switch select
- col_sel_o, output, N_COLS, one-hot column switch select
- pixel_data_o, output, ADC_W, last captured real sample
- pixel_row_o, output, CNT_W, row tag of pixel_data_o
- pixel_col_o, output, CNT_W, column tag of pixel_data_o
- pixel_valid_o, output, 1, one-cycle pulse on new capture
- leds_o, output, 8, LED display bus
- frame_done_o, output, 1, one-cycle pulse when the row count reaches N_ROWS

Behaviour:
- Reset (asynchronous, active-high) clears all registers:
  - counts, timers, pixel_data/row/col = 0; primed = 0; leds_o = 0
  - pixel_valid_o = 0; frame_done_o = 0
  - Reset mid-frame aborts immediately; there is no pending state.
- Counters (registered, update on clk_i rising edge):
  - 00 loads 0; 01/11 hold; 10 adds 1.
  - Increment wraps from 2^CNT_W-1 to 0.
  - Row and column counters are independent, with no carry between them.
- Selects (combinational decode of counter registers only):
  - row_sel_o[i] = (count_row == i); col_sel_o[j] = (count_col == j).
  - All select bits are 0 when the count is >= N.
- Timers (one instance each for settle and LED):
  - Enable low: reload to CYCLES-1.
  - Enable high and value != 0: decrement.
  - done = enable AND value == 0 (combinational).
  - Consequence: done first asserts in the CYCLES-th consecutive enabled cycle and stays high while enable is held.
  - Deasserting enable for one cycle restarts the full count.
- Capture:
  - primed clears on any cycle with oprow_i==00.
  - An eoadc_i while primed=0 sets primed and discards the data (dummy conversion); pixel_valid_o stays 0.
  - An eoadc_i while primed=1 registers adc_data_i, count_row, count_col (pre-update values of the same cycle) and pulses pixel_valid_o in the next cycle.
  - eoadc_i coincident with oprow_i==00: treat the sample as dummy (clear wins; primed stays 0).
- LEDs: while enleds_i=1, leds_o = pixel_data_o[ADC_W-1:ADC_W-8]; otherwise leds_o = 0 (registered).
- frame_done_o is a registered one-cycle pulse, asserted in the cycle after a row increment that produces count_row == N_ROWS.
- Back-to-back ops on every cycle are legal and must be honoured.

Decomposition:
- Shared package nxm_matrix_pkg holds:
  - op-code constants OP_CLR=2'b00, OP_HOLD=2'b01, OP_INC=2'b10
  - N_ROWS/N_COLS defaults
  - FSM and datapath both import these encodings.
- One sub-module, nxm_dwell_timer (params CYCLES, TMR_W; ports clk_i, rst_i, en_i, done_o), instantiated twice.

Test Plan:
- Reset mid-count with both counters at 1 -> counts 0, selects 01/01, pixel_valid_o 0, leds_o 0 in the same cycle as rst_i.
- SETTLE_CYCLES=4, enset_i held high -> zset_o rises in the 4th high cycle. Drop enset_i for 1 cycle, then re-raise -> zset_o after 4 more cycles.
- Op sequence col INC, INC, CLR with row INC -> count_col 1, 2, 0 and count_row 1. col_sel_o goes 10, 00 (count 2 >= N_COLS), 01.
- Frame with adc_data_i=0xABC:
  - First eoadc_i after clear -> no valid pulse.
  - Second eoadc_i at (0,0) -> pixel_valid_o pulse with data 0xABC, row 0, col 0.
  - enleds_i -> leds_o = 0xAB.
- Full 2x2 scan driven by an FSM model -> 4 valid pulses tagged (0,0),(0,1),(1,0),(1,1), then a frame_done_o pulse once count_row reaches 2.
- eoadc_i in the same cycle as oprow_i=00 -> sample discarded; the next eoadc_i is also discarded (dummy).
